// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - Shared receiver FSM encoding, oversample ratio and baud tick helper.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_e;

    // Clocks per oversample tick, truncated, never below one.
    function automatic int tick_period(input int clk_hz, input int baud);
        int p;
        p = clk_hz / (baud * OVERSAMPLE);
        return (p < 1) ? 1 : p;
    endfunction

endpackage

// File: rtl/uart_rx_buffered_if.sv
// rtl/uart_rx_buffered_if.sv - Received-packet pop handshake between the receive FIFO and its consumer.
interface uart_rx_buffered_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    logic                          packet_ready;
    logic [DATA_BITS-1:0]          uart_packet;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          packet_ack;

    modport master (
        output packet_ready,
        output uart_packet,
        output fifo_count,
        input  packet_ack
    );

    modport slave (
        input  packet_ready,
        input  uart_packet,
        input  fifo_count,
        output packet_ack
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - Single-clock first-word fall-through FIFO with synchronous flush.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign count    = wr_ptr - rd_ptr;
    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign pop_ok   = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/uart_rx_buffered.sv
// rtl/uart_rx_buffered.sv - 16x oversampling UART receiver feeding a FWFT FIFO; parity under UART_RX_PARITY_EN.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int SYS_CLK_SPEED = 100_000_000,
    parameter int BAUD_RATE     = 115200,
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD    = 1'b0
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               HALT_flag,
    input  logic               rx,
    input  logic               err_clr,
    output logic               frame_err,
    output logic               overrun_err,
    output logic               parity_err,
    uart_rx_buffered_if.master pkt
);
    localparam int TICK = tick_period(SYS_CLK_SPEED, BAUD_RATE);
    localparam int TW   = $clog2(TICK + 1);

    logic            rx_meta, rx_sync;
    rx_state_e       state, state_nx;
    logic [TW-1:0]   tick_cnt;
    logic [3:0]      os_cnt;
    logic [3:0]      bit_cnt;
    logic            s7, s8;
    logic [DATA_BITS-1:0] shreg;
    logic            push_pend;
    logic            tick, mid, bit_end, maj;
    logic            run, shift_en, push_req, frame_set;
    logic            push, pop, overrun_set;
    logic            fifo_empty, fifo_full, fifo_flush;
`ifdef UART_RX_PARITY_EN
    logic            parity_set;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    assign tick    = (tick_cnt == TW'(TICK - 1));
    assign mid     = tick && (os_cnt == 4'd9);
    assign bit_end = tick && (os_cnt == 4'(OVERSAMPLE - 1));
    // Majority of ticks 7, 8 and the live sample at tick 9.
    assign maj     = (s7 & s8) | (s7 & rx_sync) | (s8 & rx_sync);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (!HALT_flag) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:  if (!rx_sync) state_nx = START;
                START: begin
                    if (mid && maj)   state_nx = IDLE;
                    else if (bit_end) state_nx = DATA;
                end
                DATA: begin
                    if (bit_end && (bit_cnt == 4'(DATA_BITS - 1)))
`ifdef UART_RX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (bit_end) state_nx = STOP;
`endif
                STOP: begin
                    if (mid) begin
                        if (!maj)                               state_nx = BREAK;
                        else if (bit_cnt == 4'(STOP_BITS - 1))  state_nx = IDLE;
                    end
                end
                BREAK: if (rx_sync) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        run        = HALT_flag && (state inside {START, DATA, PARITY, STOP});
        shift_en   = HALT_flag && (state == DATA) && mid;
        push_req   = HALT_flag && (state == STOP) && mid && maj
                     && (bit_cnt == 4'(STOP_BITS - 1));
        frame_set  = HALT_flag && (state == STOP) && mid && !maj;
`ifdef UART_RX_PARITY_EN
        parity_set = HALT_flag && (state == PARITY) && mid
                     && (maj != (^shreg ^ PARITY_ODD));
`endif
    end

    // Bit timing restarts from zero whenever the receiver is not mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            os_cnt   <= '0;
            bit_cnt  <= '0;
            s7       <= 1'b0;
            s8       <= 1'b0;
        end else if (!run) begin
            tick_cnt <= '0;
            os_cnt   <= '0;
            bit_cnt  <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                os_cnt <= os_cnt + 1'b1;
                if (os_cnt == 4'd7) s7 <= rx_sync;
                if (os_cnt == 4'd8) s8 <= rx_sync;
            end
            if (state_nx != state) bit_cnt <= '0;
            else if (bit_end)      bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            push_pend <= 1'b0;
        end else begin
            if (shift_en) shreg <= {maj, shreg[DATA_BITS-1:1]};
            push_pend <= push_req;
        end
    end

    assign push        = push_pend && HALT_flag;
    assign pop         = pkt.packet_ack && !fifo_empty;
    assign overrun_set = push && fifo_full && !pop;
    assign fifo_flush  = !HALT_flag;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (fifo_flush),
        .push      (push),
        .push_data (shreg),
        .pop       (pkt.packet_ack),
        .pop_data  (pkt.uart_packet),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (pkt.fifo_count)
    );

    assign pkt.packet_ready = !fifo_empty;

    // Setting wins over err_clr in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (frame_set)        frame_err   <= 1'b1;
            else if (err_clr)     frame_err   <= 1'b0;
            if (overrun_set)      overrun_err <= 1'b1;
            else if (err_clr)     overrun_err <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           parity_err <= 1'b0;
        else if (parity_set)  parity_err <= 1'b1;
        else if (err_clr)     parity_err <= 1'b0;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
